// File: rtl/trap_ctrl_pkg.sv
// Shared types for the machine-mode trap controller: privilege levels,
// trap cause codes and the redirect FSM states.
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_M = 2'b11
    } priv_e;

    typedef enum logic [4:0] {
        CAUSE_INSN_ACCESS  = 5'd1,
        CAUSE_ILLEGAL      = 5'd2,
        CAUSE_LOAD_ACCESS  = 5'd5,
        CAUSE_STORE_ACCESS = 5'd7,
        CAUSE_ECALL_U      = 5'd8,
        CAUSE_ECALL_M      = 5'd11
    } cause_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRAP_REQ = 2'd1,
        RET_REQ  = 2'd2
    } trap_state_e;

    // ECALL cause depends on the privilege the call was made from.
    function automatic cause_e ecall_cause(input priv_e p);
        return (p == PRIV_M) ? CAUSE_ECALL_M : CAUSE_ECALL_U;
    endfunction

endpackage

// File: rtl/trap_ctrl_csr_file.sv
// Trap CSR storage: mepc/mcause/mtval/mtvec and the previous-privilege field,
// updated on trap entry, mret and privileged mtvec writes.
module trap_csr_file
    import trap_ctrl_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  priv_e           cur_priv,
    input  logic            trap_take,
    input  logic [XLEN-1:0] trap_pc,
    input  cause_e          trap_cause,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_take,
    input  logic            mtvec_we,
    input  logic [XLEN-1:0] mtvec_wdata,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] mtval,
    output logic [XLEN-1:0] mtvec,
    output priv_e           mpp
);

    logic [XLEN-1:0] mepc_reg;
    logic [XLEN-1:0] mcause_reg;
    logic [XLEN-1:0] mtval_reg;
    logic [XLEN-1:0] mtvec_reg;
    priv_e           mpp_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mepc_reg   <= '0;
            mcause_reg <= '0;
            mtval_reg  <= '0;
            mtvec_reg  <= {MTVEC_RESET[XLEN-1:2], 2'b00};
            mpp_reg    <= PRIV_U;
        end else begin
            if (trap_take) begin
                mepc_reg   <= trap_pc;
                mcause_reg <= {{(XLEN-5){1'b0}}, trap_cause};
                mtval_reg  <= trap_tval;
                mpp_reg    <= cur_priv;
            end else if (mret_take) begin
                mpp_reg <= PRIV_U;
            end
            // Gated on the privilege before the edge, so a write issued in the
            // same cycle as a U-mode trap is still dropped.
            if (mtvec_we && (cur_priv == PRIV_M)) begin
                mtvec_reg <= {mtvec_wdata[XLEN-1:2], 2'b00};
            end
        end
    end

    assign mepc   = mepc_reg;
    assign mcause = mcause_reg;
    assign mtval  = mtval_reg;
    assign mtvec  = mtvec_reg;
    assign mpp    = mpp_reg;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: prioritises MPU faults, ecall and mret,
// switches privilege and issues one fetch redirect per event over valid/ready.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fault_exec,
    input  logic            fault_load,
    input  logic            fault_store,
    input  logic [XLEN-1:0] fault_addr,
    input  logic [XLEN-1:0] pc,
    input  logic            ecall,
    input  logic            mret,
    input  logic            mtvec_we,
    input  logic [XLEN-1:0] mtvec_wdata,
    output priv_e           cur_priv,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] mtval,
    output logic [XLEN-1:0] mtvec
);

    trap_state_e     state_reg, state_next;
    priv_e           cur_priv_reg, cur_priv_next;
    logic [XLEN-1:0] redirect_pc_reg, redirect_pc_next;

    logic            trap_take;
    logic            mret_take;
    cause_e          trap_cause;
    logic [XLEN-1:0] trap_tval;
    priv_e           mpp;

    always_comb begin
        state_next       = state_reg;
        cur_priv_next    = cur_priv_reg;
        redirect_pc_next = redirect_pc_reg;
        trap_take        = 1'b0;
        mret_take        = 1'b0;
        trap_cause       = CAUSE_ILLEGAL;
        trap_tval        = '0;
        case (state_reg)
            IDLE: begin
                if (fault_exec) begin
                    trap_take  = 1'b1;
                    trap_cause = CAUSE_INSN_ACCESS;
                    trap_tval  = fault_addr;
                end else if (fault_load) begin
                    trap_take  = 1'b1;
                    trap_cause = CAUSE_LOAD_ACCESS;
                    trap_tval  = fault_addr;
                end else if (fault_store) begin
                    trap_take  = 1'b1;
                    trap_cause = CAUSE_STORE_ACCESS;
                    trap_tval  = fault_addr;
                end else if (ecall) begin
                    trap_take  = 1'b1;
                    trap_cause = ecall_cause(cur_priv_reg);
                end else if (mret) begin
                    // mret from user mode is an illegal instruction.
                    if (cur_priv_reg == PRIV_M) begin
                        mret_take = 1'b1;
                    end else begin
                        trap_take  = 1'b1;
                        trap_cause = CAUSE_ILLEGAL;
                    end
                end
                if (trap_take) begin
                    state_next       = TRAP_REQ;
                    cur_priv_next    = PRIV_M;
                    redirect_pc_next = mtvec;
                end else if (mret_take) begin
                    state_next       = RET_REQ;
                    cur_priv_next    = mpp;
                    redirect_pc_next = mepc;
                end
            end
            TRAP_REQ, RET_REQ: begin
                if (redirect_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cur_priv_reg    <= PRIV_M;
            redirect_pc_reg <= '0;
        end else begin
            state_reg       <= state_next;
            cur_priv_reg    <= cur_priv_next;
            redirect_pc_reg <= redirect_pc_next;
        end
    end

    trap_csr_file #(
        .XLEN        (XLEN),
        .MTVEC_RESET (MTVEC_RESET)
    ) u_csr (
        .clk         (clk),
        .rst_n       (rst_n),
        .cur_priv    (cur_priv_reg),
        .trap_take   (trap_take),
        .trap_pc     (pc),
        .trap_cause  (trap_cause),
        .trap_tval   (trap_tval),
        .mret_take   (mret_take),
        .mtvec_we    (mtvec_we),
        .mtvec_wdata (mtvec_wdata),
        .mepc        (mepc),
        .mcause      (mcause),
        .mtval       (mtval),
        .mtvec       (mtvec),
        .mpp         (mpp)
    );

    // Valid comes straight from the registered state: no path from ready.
    assign redirect_valid = (state_reg != IDLE);
    assign redirect_pc    = redirect_pc_reg;
    assign cur_priv       = cur_priv_reg;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed and randomized checks of trap_ctrl against a transaction-level
// reference model of the trap/return rules.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fault_exec = 1'b0, fault_load = 1'b0, fault_store = 1'b0;
    logic [31:0] fault_addr = '0, pc = '0, mtvec_wdata = '0;
    logic        ecall = 1'b0, mret = 1'b0, mtvec_we = 1'b0;
    logic        redirect_ready = 1'b0;
    priv_e       cur_priv;
    logic        redirect_valid;
    logic [31:0] redirect_pc, mepc, mcause, mtval, mtvec;

    int n_checks = 0;
    int n_fail   = 0;
    int n_step   = 0;

    // Reference model state
    priv_e       m_priv, m_mpp;
    logic [31:0] m_mepc, m_mcause, m_mtval, m_mtvec, m_target;
    bit          m_busy;

    trap_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fault_exec     (fault_exec),
        .fault_load     (fault_load),
        .fault_store    (fault_store),
        .fault_addr     (fault_addr),
        .pc             (pc),
        .ecall          (ecall),
        .mret           (mret),
        .mtvec_we       (mtvec_we),
        .mtvec_wdata    (mtvec_wdata),
        .cur_priv       (cur_priv),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .mepc           (mepc),
        .mcause         (mcause),
        .mtval          (mtval),
        .mtvec          (mtvec)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        logic [31:0] new_mtvec;
        logic [31:0] tv;
        int          code;
        if (!rst_n) begin
            m_priv = PRIV_M; m_mpp = PRIV_U; m_mepc = 0; m_mcause = 0; m_mtval = 0;
            m_mtvec = 32'h0000_0100; m_busy = 0; m_target = 0;
            return;
        end
        new_mtvec = (mtvec_we && m_priv == PRIV_M) ? (mtvec_wdata & 32'hFFFF_FFFC) : m_mtvec;
        code = -1;
        tv = 0;
        if (m_busy) begin
            if (redirect_ready) m_busy = 0;
        end else begin
            if (fault_exec) begin code = 1; tv = fault_addr; end
            else if (fault_load) begin code = 5; tv = fault_addr; end
            else if (fault_store) begin code = 7; tv = fault_addr; end
            else if (ecall) code = (m_priv == PRIV_M) ? 11 : 8;
            else if (mret && m_priv == PRIV_U) code = 2;
            if (code >= 0) begin
                m_mepc = pc; m_mcause = code; m_mtval = tv; m_mpp = m_priv;
                m_priv = PRIV_M; m_target = m_mtvec; m_busy = 1;
            end else if (mret) begin
                m_priv = m_mpp; m_mpp = PRIV_U; m_target = m_mepc; m_busy = 1;
            end
        end
        m_mtvec = new_mtvec;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        n_step++;
        $display("txn %0d: rst_n=%b ev=%b%b%b%b%b we=%b rdy=%b -> priv=%0d vld=%b rpc=%h cause=%0d", n_step, rst_n,
                 fault_exec, fault_load, fault_store, ecall, mret, mtvec_we, redirect_ready, cur_priv, redirect_valid,
                 redirect_pc, mcause);
    endtask

    task automatic clear_inputs();
        fault_exec = 0; fault_load = 0; fault_store = 0; ecall = 0; mret = 0;
        mtvec_we = 0; redirect_ready = 0;
    endtask

    task automatic accept();
        redirect_ready = 1; step(); redirect_ready = 0;
    endtask

    task automatic go_user();
        mret = 1; step(); mret = 0; accept();
    endtask

    task automatic test_reset();
        clear_inputs(); rst_n = 0; step(); rst_n = 1;
        n_checks++; if (cur_priv !== PRIV_M) begin n_fail++; $display("FAIL rst_priv got %0d want %0d", cur_priv, PRIV_M); end
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rst_rpc got %h want 0", redirect_pc); end
        n_checks++; if (mepc !== 32'h0) begin n_fail++; $display("FAIL rst_mepc got %h want 0", mepc); end
        n_checks++; if (mcause !== 32'h0) begin n_fail++; $display("FAIL rst_mcause got %h want 0", mcause); end
        n_checks++; if (mtval !== 32'h0) begin n_fail++; $display("FAIL rst_mtval got %h want 0", mtval); end
        n_checks++; if (mtvec !== 32'h0000_0100) begin n_fail++; $display("FAIL rst_mtvec got %h want 100", mtvec); end
    endtask

    task automatic test_store_fault();
        mret = 1; step(); mret = 0;
        n_checks++; if (cur_priv !== PRIV_U) begin n_fail++; $display("FAIL ret_priv got %0d want %0d", cur_priv, PRIV_U); end
        n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL ret_valid got %b want 1", redirect_valid); end
        accept();
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL ret_done got %b want 0", redirect_valid); end
        fault_store = 1; fault_addr = 32'h1000_0000; pc = 32'h0000_2040; step(); fault_store = 0;
        n_checks++; if (mcause !== 32'd7) begin n_fail++; $display("FAIL st_mcause got %h want 7", mcause); end
        n_checks++; if (mtval !== 32'h1000_0000) begin n_fail++; $display("FAIL st_mtval got %h want 10000000", mtval); end
        n_checks++; if (mepc !== 32'h0000_2040) begin n_fail++; $display("FAIL st_mepc got %h want 2040", mepc); end
        n_checks++; if (cur_priv !== PRIV_M) begin n_fail++; $display("FAIL st_priv got %0d want %0d", cur_priv, PRIV_M); end
        n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL st_valid got %b want 1", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL st_rpc got %h want 100", redirect_pc); end
        accept();
    endtask

    task automatic test_priority();
        go_user();
        fault_exec = 1; fault_load = 1; ecall = 1; fault_addr = 32'h0000_3000; pc = 32'h0000_2100;
        step(); clear_inputs();
        n_checks++; if (mcause !== 32'd1) begin n_fail++; $display("FAIL pri_mcause got %h want 1", mcause); end
        n_checks++; if (mtval !== 32'h0000_3000) begin n_fail++; $display("FAIL pri_mtval got %h want 3000", mtval); end
        n_checks++; if (mepc !== 32'h0000_2100) begin n_fail++; $display("FAIL pri_mepc got %h want 2100", mepc); end
        accept();
        n_checks++; if (mcause !== 32'd1) begin n_fail++; $display("FAIL pri_kept got %h want 1", mcause); end
    endtask

    task automatic test_back_to_back();
        go_user();
        fault_store = 1; fault_addr = 32'h1111_0000; pc = 32'h0000_3000; step(); clear_inputs();
        for (int i = 0; i < 4; i++) begin
            fault_load = (i == 1); fault_addr = 32'hDEAD_0000; pc = 32'h0000_4000;
            step();
            n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", i, redirect_valid); end
            n_checks++; if (redirect_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL bp_rpc[%0d] got %h want 100", i, redirect_pc); end
            n_checks++; if (mcause !== 32'd7) begin n_fail++; $display("FAIL bp_mcause[%0d] got %h want 7", i, mcause); end
            n_checks++; if (mtval !== 32'h1111_0000) begin n_fail++; $display("FAIL bp_mtval[%0d] got %h want 11110000", i, mtval); end
            n_checks++; if (mepc !== 32'h0000_3000) begin n_fail++; $display("FAIL bp_mepc[%0d] got %h want 3000", i, mepc); end
        end
        clear_inputs(); accept();
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got %b want 0", redirect_valid); end
    endtask

    task automatic test_mret();
        go_user();
        ecall = 1; pc = 32'h0000_2044; step(); ecall = 0;
        n_checks++; if (mcause !== 32'd8) begin n_fail++; $display("FAIL ecu_mcause got %h want 8", mcause); end
        n_checks++; if (mtval !== 32'h0) begin n_fail++; $display("FAIL ecu_mtval got %h want 0", mtval); end
        accept();
        mret = 1; step(); mret = 0;
        n_checks++; if (redirect_pc !== 32'h0000_2044) begin n_fail++; $display("FAIL mret_rpc got %h want 2044", redirect_pc); end
        n_checks++; if (cur_priv !== PRIV_U) begin n_fail++; $display("FAIL mret_priv got %0d want %0d", cur_priv, PRIV_U); end
        n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL mret_valid got %b want 1", redirect_valid); end
        accept();
    endtask

    task automatic test_illegal_mtvec();
        mret = 1; pc = 32'h0000_5000; step(); mret = 0;
        n_checks++; if (mcause !== 32'd2) begin n_fail++; $display("FAIL ill_mcause got %h want 2", mcause); end
        n_checks++; if (mtval !== 32'h0) begin n_fail++; $display("FAIL ill_mtval got %h want 0", mtval); end
        n_checks++; if (cur_priv !== PRIV_M) begin n_fail++; $display("FAIL ill_priv got %0d want %0d", cur_priv, PRIV_M); end
        mtvec_we = 1; mtvec_wdata = 32'h0000_0203; step(); mtvec_we = 0;
        n_checks++; if (mtvec !== 32'h0000_0200) begin n_fail++; $display("FAIL mtvec_m got %h want 200", mtvec); end
        n_checks++; if (redirect_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL mtvec_hold got %h want 100", redirect_pc); end
        accept();
        // M-mode trap with a simultaneous mtvec write: redirect uses the old vector.
        fault_load = 1; fault_addr = 32'h0000_6000; pc = 32'h0000_6004; mtvec_we = 1; mtvec_wdata = 32'h0000_0404;
        step(); clear_inputs();
        n_checks++; if (mtvec !== 32'h0000_0404) begin n_fail++; $display("FAIL same_mtvec got %h want 404", mtvec); end
        n_checks++; if (redirect_pc !== 32'h0000_0200) begin n_fail++; $display("FAIL same_rpc got %h want 200", redirect_pc); end
        n_checks++; if (mcause !== 32'd5) begin n_fail++; $display("FAIL same_mcause got %h want 5", mcause); end
        accept();
        mret = 1; step(); mret = 0;
        n_checks++; if (cur_priv !== PRIV_M) begin n_fail++; $display("FAIL mpp_m got %0d want %0d", cur_priv, PRIV_M); end
        n_checks++; if (redirect_pc !== 32'h0000_6004) begin n_fail++; $display("FAIL mpp_rpc got %h want 6004", redirect_pc); end
        accept();
        mret = 1; step(); mret = 0;
        n_checks++; if (cur_priv !== PRIV_U) begin n_fail++; $display("FAIL mpp_u got %0d want %0d", cur_priv, PRIV_U); end
        accept();
        mtvec_we = 1; mtvec_wdata = 32'h0000_0303; step(); mtvec_we = 0;
        n_checks++; if (mtvec !== 32'h0000_0404) begin n_fail++; $display("FAIL mtvec_u got %h want 404", mtvec); end
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL mtvec_u_vld got %b want 0", redirect_valid); end
    endtask

    task automatic test_reset_mid();
        fault_exec = 1; fault_addr = 32'h0000_7000; pc = 32'h0000_7004; step(); fault_exec = 0;
        n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pend got %b want 1", redirect_valid); end
        rst_n = 0; step(); rst_n = 1;
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid got %b want 0", redirect_valid); end
        n_checks++; if (cur_priv !== PRIV_M) begin n_fail++; $display("FAIL rm_priv got %0d want %0d", cur_priv, PRIV_M); end
        n_checks++; if (mtvec !== 32'h0000_0100) begin n_fail++; $display("FAIL rm_mtvec got %h want 100", mtvec); end
        n_checks++; if ((mepc | mcause | mtval | redirect_pc) !== 32'h0) begin n_fail++; $display("FAIL rm_csrs got %h/%h/%h/%h want 0", mepc, mcause, mtval, redirect_pc); end
        step();
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rm_dropped got %b want 0", redirect_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n          = ($urandom_range(0, 99) != 0);
            fault_exec     = ($urandom_range(0, 11) == 0);
            fault_load     = ($urandom_range(0, 11) == 0);
            fault_store    = ($urandom_range(0, 11) == 0);
            ecall          = ($urandom_range(0, 9) == 0);
            mret           = ($urandom_range(0, 4) == 0);
            mtvec_we       = ($urandom_range(0, 9) == 0);
            mtvec_wdata    = $urandom;
            fault_addr     = $urandom;
            pc             = $urandom;
            redirect_ready = $urandom_range(0, 1) == 1;
            step();
            n_checks++; if (cur_priv !== m_priv) begin n_fail++; $display("FAIL rnd_priv[%0d] got %0d want %0d", i, cur_priv, m_priv); end
            n_checks++; if (redirect_valid !== m_busy) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b want %b", i, redirect_valid, m_busy); end
            n_checks++; if (redirect_pc !== m_target) begin n_fail++; $display("FAIL rnd_rpc[%0d] got %h want %h", i, redirect_pc, m_target); end
            n_checks++; if (mepc !== m_mepc) begin n_fail++; $display("FAIL rnd_mepc[%0d] got %h want %h", i, mepc, m_mepc); end
            n_checks++; if (mcause !== m_mcause) begin n_fail++; $display("FAIL rnd_mcause[%0d] got %h want %h", i, mcause, m_mcause); end
            n_checks++; if (mtval !== m_mtval) begin n_fail++; $display("FAIL rnd_mtval[%0d] got %h want %h", i, mtval, m_mtval); end
            n_checks++; if (mtvec !== m_mtvec) begin n_fail++; $display("FAIL rnd_mtvec[%0d] got %h want %h", i, mtvec, m_mtvec); end
        end
        clear_inputs();
        rst_n = 1;
    endtask

    initial begin
        #2;
        test_reset();
        test_store_fault();
        test_priority();
        test_back_to_back();
        test_mret();
        test_illegal_mtvec();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
